// File: rtl/ether_pkg.sv
// Shared constants, FSM state type and the CRC-32 single-bit step used by
// the receive-side frame checker.
package ether_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  // Bit positions inside the status vector {align_err, len_err, crc_err}
  localparam int STAT_CRC   = 0;
  localparam int STAT_LEN   = 1;
  localparam int STAT_ALIGN = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } frame_state_t;

  // One reflected CRC-32 step for a single serial bit
  function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic b);
    logic [31:0] shifted;
    shifted = {1'b0, crc[31:1]};
    if ((crc[0] ^ b) == 1'b1) begin
      crc32_bit = shifted ^ CRC32_POLY_REFL;
    end else begin
      crc32_bit = shifted;
    end
  endfunction

endpackage

// File: rtl/frame_check_if.sv
// Dibit input stream plus byte strobe and end-of-frame verdict outputs.
interface frame_check_if;

  logic        axiiv;
  logic [1:0]  axiid;
  logic        axiov;
  logic [7:0]  axiod;
  logic        done;
  logic        ok;
  logic [10:0] len;
  logic [2:0]  status;

  // Producer side: drives the dibit stream, observes bytes and verdicts
  modport master (
    output axiiv, axiid,
    input  axiov, axiod, done, ok, len, status
  );

  // Checker side: consumes the dibit stream, produces bytes and verdicts
  modport slave (
    input  axiiv, axiid,
    output axiov, axiod, done, ok, len, status
  );

endinterface

// File: rtl/crc32_dibit.sv
// Reflected CRC-32 register that absorbs one dibit per enabled cycle,
// bit 0 first. Asserting init together with enable restarts the CRC and
// absorbs the dibit in the same cycle.
module crc32_dibit
  import ether_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [1:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;
  logic [31:0] w_base;
  logic [31:0] w_next;

  // Two serial steps per cycle: earlier wire bit (data[0]) first
  always_comb begin
    w_base = r_crc;
    if (i_init) begin
      w_base = CRC32_INIT;
    end else begin
      w_base = r_crc;
    end
    w_next = crc32_bit(crc32_bit(w_base, i_data[0]), i_data[1]);
  end

  // CRC register: update on enable, restart on a bare init, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc <= CRC32_INIT;
    end else if (i_en) begin
      r_crc <= w_next;
    end else if (i_init) begin
      r_crc <= CRC32_INIT;
    end else begin
      r_crc <= r_crc;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/frame_check.sv
// Packs the post-preamble dibit stream into bytes, forwards each byte as a
// one-cycle strobe, and at the first idle cycle after a frame reports the
// byte count and a verdict covering FCS residue, length and alignment.
module frame_check
  import ether_pkg::*;
#(
  parameter int MIN_BYTES = 64,
  parameter int MAX_BYTES = 1518
) (
  input logic         clk,
  input logic         rst,
  frame_check_if.slave bus
);

  localparam logic [10:0] LEN_SAT = 11'd2047;
  localparam logic [10:0] LEN_MIN = 11'(MIN_BYTES);
  localparam logic [10:0] LEN_MAX = 11'(MAX_BYTES);

  frame_state_t r_state;
  frame_state_t w_state_next;
  logic         w_consume;
  logic         w_finalise;
  logic         w_crc_init;
  logic [31:0]  w_crc;
  logic [2:0]   w_status;

  logic [1:0]   r_k;
  logic [5:0]   r_byte;
  logic [10:0]  r_count;
  logic         r_axiov;
  logic [7:0]   r_axiod;
  logic         r_done;
  logic         r_ok;
  logic [10:0]  r_len;
  logic [2:0]   r_status;

  crc32_dibit u_crc (
    .clk    (clk),
    .rst    (rst),
    .i_init (w_crc_init),
    .i_en   (w_consume),
    .i_data (bus.axiid),
    .o_crc  (w_crc)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and per-cycle control: consume a dibit or close the frame
  always_comb begin
    w_state_next = r_state;
    w_consume    = 1'b0;
    w_finalise   = 1'b0;
    w_crc_init   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.axiiv) begin
          w_state_next = RECV;
          w_consume    = 1'b1;
          w_crc_init   = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      RECV: begin
        if (bus.axiiv) begin
          w_consume = 1'b1;
        end else begin
          w_finalise   = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Verdict flags evaluated against the state accumulated over the frame
  always_comb begin
    w_status            = 3'b000;
    w_status[STAT_CRC]  = (w_crc != CRC32_RESIDUE);
    w_status[STAT_LEN]  = (r_count < LEN_MIN) || (r_count > LEN_MAX) ||
                          (r_count == LEN_SAT);
    w_status[STAT_ALIGN] = (r_k != 2'd0);
  end

  // Byte assembly, saturating byte count and registered outputs.
  // Counters clear at finalisation so a frame starting in the done cycle
  // begins with fresh state; a trailing partial byte is simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k      <= 2'd0;
      r_byte   <= 6'd0;
      r_count  <= 11'd0;
      r_axiov  <= 1'b0;
      r_axiod  <= 8'd0;
      r_done   <= 1'b0;
      r_ok     <= 1'b0;
      r_len    <= 11'd0;
      r_status <= 3'b000;
    end else begin
      r_axiov <= 1'b0;
      r_done  <= 1'b0;
      r_ok    <= 1'b0;
      if (w_consume) begin
        r_k <= r_k + 2'd1;
        case (r_k)
          2'd0:    r_byte[1:0] <= bus.axiid;
          2'd1:    r_byte[3:2] <= bus.axiid;
          2'd2:    r_byte[5:4] <= bus.axiid;
          default: begin
            r_axiod <= {bus.axiid, r_byte};
            r_axiov <= 1'b1;
            if (r_count != LEN_SAT) begin
              r_count <= r_count + 11'd1;
            end else begin
              r_count <= r_count;
            end
          end
        endcase
      end else if (w_finalise) begin
        r_done   <= 1'b1;
        r_ok     <= (w_status == 3'b000);
        r_len    <= r_count;
        r_status <= w_status;
        r_k      <= 2'd0;
        r_count  <= 11'd0;
      end else begin
        r_k     <= r_k;
        r_count <= r_count;
      end
    end
  end

  assign bus.axiov  = r_axiov;
  assign bus.axiod  = r_axiod;
  assign bus.done   = r_done;
  assign bus.ok     = r_ok;
  assign bus.len    = r_len;
  assign bus.status = r_status;

endmodule

// File: tb/tb_frame_check.sv
// Self-checking bench for frame_check: frames are built as byte arrays with
// a standard Ethernet FCS, streamed as dibits, and the forwarded bytes and
// end-of-frame verdicts are compared with a byte-level reference model.
module tb_frame_check;

  localparam logic [31:0] POLY = 32'hEDB88320;

  typedef struct packed {
    logic        ok;
    logic [10:0] len;
    logic [2:0]  status;
  } verdict_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] frm[$];
  logic [7:0] rx[$];
  verdict_t   done_q[$];

  always #10 clk = ~clk;

  frame_check_if bus ();

  frame_check #(.MIN_BYTES(64), .MAX_BYTES(1518)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Monitor: collect byte strobes and verdicts; strobe and done never overlap
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.axiov === 1'b1) rx.push_back(bus.axiod);
      if (bus.done === 1'b1) begin
        done_q.push_back({bus.ok, bus.len, bus.status});
        checks++;
        if (bus.axiov !== 1'b0) begin
          errors++;
          $display("FAIL strobe_overlap axiov=%b required 0", bus.axiov);
        end
      end
    end
  end

  // Standard Ethernet CRC over the first n bytes of the frame (final XOR applied)
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = frm[i];
      for (int j = 0; j < 8; j++) begin
        if ((c[0] ^ b[j]) == 1'b1) c = (c >> 1) ^ POLY;
        else                      c = c >> 1;
      end
    end
    return ~c;
  endfunction

  // Rewrite the last four bytes with the FCS of the preceding bytes
  task automatic fix_fcs();
    int n;
    logic [31:0] c;
    n = frm.size();
    c = ref_crc(n - 4);
    frm[n-4] = c[7:0];
    frm[n-3] = c[15:8];
    frm[n-2] = c[23:16];
    frm[n-1] = c[31:24];
  endtask

  task automatic build_frame(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
    fix_fcs();
  endtask

  // Reference verdict {align, len, crc} from frame rules
  function automatic logic [2:0] exp_status(input int extra);
    int n;
    int lv;
    logic crc_bad;
    n  = frm.size();
    lv = (n > 2047) ? 2047 : n;
    crc_bad = (extra != 0) ||
              (ref_crc(n - 4) != {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
    return {(extra % 4) != 0, (lv < 64) || (lv > 1518), crc_bad};
  endfunction

  // Stream frm as dibits, then one low cycle. Optional checks: done high
  // when the first dibit is driven, and first-byte latency/value 8'h39.
  // abort_at >= 0 pulses rst instead of driving that dibit.
  task automatic send_frame(input int extra, input bit chk_done, input bit chk_first,
                            input int abort_at);
    logic [7:0] b;
    for (int i = 0; i < frm.size(); i++) begin
      b = frm[i];
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (abort_at == i * 4 + j) begin
          rst = 1'b1;
          bus.axiiv = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        if (chk_done && i == 0 && j == 0) begin
          checks++;
          if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_dibit_in_done done=%b required 1", bus.done);
          end
        end
        if (chk_first && i == 0 && j == 3) begin
          checks++;
          if (bus.axiov !== 1'b0) begin
            errors++;
            $display("FAIL early_strobe axiov=%b required 0", bus.axiov);
          end
        end
        if (chk_first && i == 1 && j == 0) begin
          checks++;
          if (bus.axiov !== 1'b1 || bus.axiod !== 8'h39) begin
            errors++;
            $display("FAIL first_byte axiov=%b axiod=%h required 1 39", bus.axiov, bus.axiod);
          end
        end
        bus.axiiv = 1'b1;
        bus.axiid = b[2*j +: 2];
      end
    end
    for (int e = 0; e < extra; e++) begin
      @(negedge clk);
      bus.axiiv = 1'b1;
      bus.axiid = 2'($urandom);
    end
    @(negedge clk);
    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;
  endtask

  // Wait (bounded) for a verdict and compare it and the forwarded bytes
  task automatic check_frame(input string name, input int extra, input bit drain);
    logic [2:0]  st;
    logic [10:0] el;
    verdict_t    v;
    int          nbad;
    st = exp_status(extra);
    el = (frm.size() > 2047) ? 11'd2047 : 11'(frm.size());
    for (int i = 0; i < 10 && done_q.size() == 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (done_q.size() == 0) begin
      errors++;
      $display("FAIL %s_done no verdict seen, required one", name);
      return;
    end
    v = done_q.pop_front();
    checks++;
    if (v.len !== el) begin
      errors++;
      $display("FAIL %s_len got %0d required %0d", name, v.len, el);
    end
    checks++;
    if (v.status !== st) begin
      errors++;
      $display("FAIL %s_status got %b required %b", name, v.status, st);
    end
    checks++;
    if (v.ok !== (st == 3'b000)) begin
      errors++;
      $display("FAIL %s_ok got %b required %b", name, v.ok, st == 3'b000);
    end
    checks++;
    if (rx.size() < frm.size()) begin
      errors++;
      $display("FAIL %s_bytecount got %0d required %0d", name, rx.size(), frm.size());
      rx.delete();
    end else begin
      nbad = 0;
      for (int i = 0; i < frm.size(); i++) begin
        if (rx.pop_front() !== frm[i]) nbad++;
      end
      if (nbad != 0) begin
        errors++;
        $display("FAIL %s_bytes got %0d wrong bytes required 0", name, nbad);
      end
    end
    if (drain) begin
      checks++;
      if (rx.size() != 0) begin
        errors++;
        $display("FAIL %s_extra_strobes got %0d required 0", name, rx.size());
      end
      rx.delete();
    end
  endtask

  task automatic test_reset();
    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.axiov, bus.axiod, bus.done, bus.ok, bus.len, bus.status} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0",
               {bus.axiov, bus.axiod, bus.done, bus.ok, bus.len, bus.status});
    end
  endtask

  task automatic test_good_frame();
    build_frame(64);
    send_frame(0, 1'b0, 1'b0, -1);
    check_frame("good64", 0, 1'b1);
  endtask

  task automatic test_bad_crc();
    build_frame(64);
    frm[10] = frm[10] ^ 8'h08;
    send_frame(0, 1'b0, 1'b0, -1);
    check_frame("badcrc", 0, 1'b1);
  endtask

  task automatic test_short();
    build_frame(60);
    send_frame(0, 1'b0, 1'b0, -1);
    check_frame("short60", 0, 1'b1);
  endtask

  task automatic test_align();
    build_frame(64);
    send_frame(1, 1'b0, 1'b0, -1);
    check_frame("align", 1, 1'b1);
  endtask

  task automatic test_byte_order();
    build_frame(64);
    frm[0] = 8'h39;
    fix_fcs();
    send_frame(0, 1'b0, 1'b1, -1);
    check_frame("byteorder", 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    build_frame(64);
    send_frame(0, 1'b0, 1'b0, 100);
    #1;
    checks++;
    if ({bus.axiov, bus.done, bus.len, bus.status} !== 16'd0) begin
      errors++;
      $display("FAIL abort_outputs got %h required 0",
               {bus.axiov, bus.done, bus.len, bus.status});
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d verdicts required 0", done_q.size());
    end
    done_q.delete();
    rx.delete();
    send_frame(0, 1'b0, 1'b0, -1);
    send_frame(0, 1'b1, 1'b0, -1);
    check_frame("b2b_a", 0, 1'b0);
    check_frame("b2b_b", 0, 1'b1);
  endtask

  task automatic test_random();
    int n;
    int extra;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(20, 100);
      build_frame(n);
      if ($urandom_range(0, 2) == 0) frm[$urandom_range(0, n - 1)] ^= 8'h01 << $urandom_range(0, 7);
      extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      send_frame(extra, 1'b0, 1'b0, -1);
      check_frame($sformatf("rand%0d", t), extra, 1'b1);
    end
  endtask

  task automatic test_length_limits();
    build_frame(1518);
    send_frame(0, 1'b0, 1'b0, -1);
    check_frame("max1518", 0, 1'b1);
    build_frame(1519);
    send_frame(0, 1'b0, 1'b0, -1);
    check_frame("over1519", 0, 1'b1);
    build_frame(2100);
    send_frame(0, 1'b0, 1'b0, -1);
    check_frame("sat2100", 0, 1'b1);
  endtask

  initial begin
    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_short();
    test_align();
    test_byte_order();
    test_back_to_back();
    test_random();
    test_length_limits();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_check.md
# frame_check

Receive-side stage directly downstream of the Ethernet preamble stripper. It consumes the 2-bit post-preamble stream, packs it into bytes, and runs a CRC-32 over the whole frame including the FCS. When each frame ends it reports the byte count and a pass/fail verdict covering FCS, length and byte alignment. Bytes are forwarded as they arrive; the verdict arrives one cycle after the frame ends, so downstream logic can commit or drop what it has buffered.

## Interface
- MIN_BYTES, 64: smallest legal frame length in bytes, FCS included.
- MAX_BYTES, 1518: largest legal frame length in bytes, FCS included.
- clk  in  1  system clock (50 MHz RMII domain).
- rst  in  1  asynchronous, active-high reset.
- axiiv  in  1  dibit valid; a frame is one maximal run of consecutive high cycles.
- axiid  in  2  dibit; bit 0 is the earlier bit on the wire.
- axiov  out  1  one-cycle strobe marking a completed byte.
- axiod  out  8  assembled byte, valid while axiov is high.
- done  out  1  one-cycle strobe at end of frame.
- ok  out  1  frame good; valid only while done is high.
- len  out  11  frame byte count, FCS included, saturating at 2047; valid while done is high.
- status  out  3  failure flags, valid while done is high: {align_err, len_err, crc_err}.

## Operation
- State machine with two states:
  - IDLE: an axiiv high cycle moves to RECV, re-initialises the CRC to 32'hFFFFFFFF and consumes that dibit.
  - RECV: every axiiv high cycle consumes one dibit. The first axiiv low cycle finalises the frame and returns to IDLE.
- Byte assembly:
  - A 2-bit dibit counter k places the dibit at byte bits [2k+1:2k], so dibits go in LSB first.
  - On k==3 the completed byte is output and the byte counter increments.
  - Example: dibits 01, 10, 11, 00 produce axiod = 8'h39.
- CRC:
  - Reflected CRC-32, polynomial 32'hEDB88320.
  - Each dibit is processed as two single-bit steps within one cycle: axiid[0] first, then axiid[1].
  - Every dibit of the frame is included, FCS included.
  - The FCS passes when the final register equals the residue 32'hDEBB20E3. No final XOR is applied.
- Verdict at finalisation:
  - crc_err = register != residue.
  - len_err = len < MIN_BYTES or len > MAX_BYTES.
  - align_err = k != 0, i.e. a trailing partial byte. The partial byte is discarded and never strobed on axiov.
  - ok = no flag set.
- len saturates at 2047. A saturated count also sets len_err.
- Reset in the middle of a frame: outputs return to reset values, state goes to IDLE, and no done is produced for the aborted frame. If axiiv is still high after rst deasserts, the remainder of that frame is treated as a new frame.

## Timing
- Reset values: axiov=0, axiod=0, done=0, ok=0, len=0, status=0, state IDLE, dibit counter 0, CRC 32'hFFFFFFFF.
- All outputs are registered.
- axiov rises the cycle after the fourth dibit of a byte is sampled. Latency is 1 cycle.
- done rises the cycle after the first axiiv low sample. ok, len and status are valid in that same cycle. At all other times done and ok are 0; len and status hold their last values.
- Back-to-back frames: the minimum gap is one low cycle. If axiiv goes high in the cycle where done is high, that cycle is the first dibit of the next frame, with fresh CRC and counters; the previous verdict is unaffected.
- axiov and done are never high in the same cycle, because the last byte strobe precedes the low sample.
- No backpressure: the block accepts a dibit every cycle that axiiv is high.

## Structure
- Package ether_pkg holds:
  - CRC32_POLY_REFL, CRC32_INIT and CRC32_RESIDUE.
  - Status bit indices: STAT_CRC=0, STAT_LEN=1, STAT_ALIGN=2.
  - The FSM state enum frame_state_t, with values IDLE and RECV.
- Sub-module crc32_dibit: 32-bit register with init and enable inputs, a 2-bit data input and a 32-bit output. It performs the two-step update combinationally and registers the result, and uses the same asynchronous reset.
- frame_check contains the FSM, the dibit and byte counters, the byte shift register, the output registers and the verdict logic.

## Test plan
- 64-byte frame (60 payload bytes plus correct FCS), 256 dibits -> 64 axiov strobes with bytes matching the payload, then done with ok=1, len=64, status=3'b000.
- Same frame with payload byte 10 bit 3 inverted -> done with ok=0, status=3'b001, len=64.
- 60-byte frame with correct FCS -> ok=0, status=3'b010, len=60.
- 257-dibit frame (valid 64-byte frame plus one extra dibit) -> 64 axiov strobes, done with len=64 and status=3'b101 (align_err, and crc_err because the CRC also absorbs the extra dibit).
- Dibits 01, 10, 11, 00 at the start of a frame -> first axiod = 8'h39, one cycle after the fourth dibit.
- rst pulsed at dibit 100 of a good frame, then two good 64-byte frames separated by one low cycle -> no done for the aborted frame; two done pulses, each with ok=1 and len=64; the second frame's first dibit is sampled in the cycle the first done is high.
